// File: rtl/wb_arb.sv
// Write-back arbiter: ALU results win the register-file write port; loads wait in a small FIFO.
// Optional WB_STATS_EN adds the kill_cnt statistics output.
module wb_arb #(
  parameter int LD_DEPTH = 2
) (
  input  logic        t2,
  input  logic        rst_n,
  input  logic        alu_v,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_d,
  input  logic        ld_v,
  output logic        ld_rdy,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_d,
  output logic        rwe,
  output logic [4:0]  wr,
  output logic [31:0] w
`ifdef WB_STATS_EN
  ,
  output logic [15:0] kill_cnt
`endif
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(LD_DEPTH - 1);

  // Load buffer storage; the kill flag marks entries superseded by a later ALU write.
  logic [4:0]    ent_rd_q   [LD_DEPTH];
  logic [31:0]   ent_data_q [LD_DEPTH];
  logic          ent_kill_q [LD_DEPTH];
  logic          ent_kill_d [LD_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          rwe_q, rwe_d;
  logic [4:0]    wr_q, wr_d;
  logic [31:0]   w_q, w_d;

  logic          ld_acc;
  logic          sel_head;
  logic          sel_ld;
  logic          push;
  logic          pop;
  logic          push_kill;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          head_kill;
  logic [3:0]    off [LD_DEPTH];
  logic          live [LD_DEPTH];
  logic          newly_killed [LD_DEPTH];
`ifdef WB_STATS_EN
  logic [2:0]    kill_inc;
  logic [15:0]   kill_cnt_q, kill_cnt_d;
  logic [16:0]   kill_sum;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Ready reflects current occupancy only; a same-cycle pop does not free a slot early.
  assign ld_rdy = (count_q < DEPTH_C);
  assign ld_acc = ld_v && ld_rdy;

  assign sel_head = !alu_v && (count_q != '0);
  assign sel_ld   = !alu_v && (count_q == '0) && ld_acc;
  assign push     = ld_acc && !sel_ld;
  assign pop      = sel_head;

  assign head_rd   = ent_rd_q[rd_ptr_q];
  assign head_data = ent_data_q[rd_ptr_q];
  assign head_kill = ent_kill_q[rd_ptr_q];

  assign push_kill = alu_v && (ld_rd == alu_rd);

  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
`ifdef WB_STATS_EN
    kill_inc = '0;
`endif
    for (int i = 0; i < LD_DEPTH; i++) begin
      off[i] = 4'(i) + 4'(LD_DEPTH) - 4'(rd_ptr_q);
      if (off[i] >= 4'(LD_DEPTH)) begin
        off[i] = off[i] - 4'(LD_DEPTH);
      end
      live[i]         = off[i] < 4'(count_q);
      newly_killed[i] = alu_v && live[i] && !ent_kill_q[i] && (ent_rd_q[i] == alu_rd);
      ent_kill_d[i]   = ent_kill_q[i] | newly_killed[i];
`ifdef WB_STATS_EN
      kill_inc = kill_inc + 3'(newly_killed[i]);
`endif
    end
    if (push) begin
      ent_kill_d[wr_ptr_q] = push_kill;
`ifdef WB_STATS_EN
      kill_inc = kill_inc + 3'(push_kill);
`endif
    end
  end

  always_comb begin
    rwe_d = 1'b0;
    wr_d  = wr_q;
    w_d   = w_q;
    if (alu_v) begin
      if (alu_rd != 5'd0) begin
        rwe_d = 1'b1;
        wr_d  = alu_rd;
        w_d   = alu_d;
      end
    end else if (sel_head) begin
      if (!head_kill && (head_rd != 5'd0)) begin
        rwe_d = 1'b1;
        wr_d  = head_rd;
        w_d   = head_data;
      end
    end else if (sel_ld) begin
      if (ld_rd != 5'd0) begin
        rwe_d = 1'b1;
        wr_d  = ld_rd;
        w_d   = ld_d;
      end
    end
  end

  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rwe_q    <= 1'b0;
      wr_q     <= '0;
      w_q      <= '0;
      for (int i = 0; i < LD_DEPTH; i++) begin
        ent_kill_q[i] <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rwe_q    <= rwe_d;
      wr_q     <= wr_d;
      w_q      <= w_d;
      for (int i = 0; i < LD_DEPTH; i++) begin
        ent_kill_q[i] <= ent_kill_d[i];
      end
    end
  end

  // Payload needs no reset: occupancy and kill flags decide whether it is ever used.
  always_ff @(posedge t2) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= ld_rd;
      ent_data_q[wr_ptr_q] <= ld_d;
    end
  end

  assign rwe = rwe_q;
  assign wr  = wr_q;
  assign w   = w_q;

`ifdef WB_STATS_EN
  assign kill_sum   = {1'b0, kill_cnt_q} + 17'(kill_inc);
  assign kill_cnt_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];

  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      kill_cnt_q <= '0;
    end else begin
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign kill_cnt = kill_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios followed by random traffic, all checked
// against a queue-based model of the write-back rules.
module tb_wb_arb;

  localparam int LD_DEPTH = 2;

  logic        t2;
  logic        rst_n;
  logic        alu_v;
  logic [4:0]  alu_rd;
  logic [31:0] alu_d;
  logic        ld_v;
  logic        ld_rdy;
  logic [4:0]  ld_rd;
  logic [31:0] ld_d;
  logic        rwe;
  logic [4:0]  wr;
  logic [31:0] w;
`ifdef WB_STATS_EN
  logic [15:0] kill_cnt;
`endif

  wb_arb #(.LD_DEPTH(LD_DEPTH)) dut (
    .t2     (t2),
    .rst_n  (rst_n),
    .alu_v  (alu_v),
    .alu_rd (alu_rd),
    .alu_d  (alu_d),
    .ld_v   (ld_v),
    .ld_rdy (ld_rdy),
    .ld_rd  (ld_rd),
    .ld_d   (ld_d),
    .rwe    (rwe),
    .wr     (wr),
    .w      (w)
`ifdef WB_STATS_EN
    ,
    .kill_cnt (kill_cnt)
`endif
  );

  // Clock and reset
  initial t2 = 1'b0;
  always #5 t2 = ~t2;

  // Reference model: pending loads in arrival order, plus the expected write port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          killed;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_q[$];
  logic        exp_rwe;
  logic [4:0]  exp_wr;
  logic [31:0] exp_w;
  int          exp_kc;
  logic        last_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    exp_rwe = 1'b0;
    exp_wr  = '0;
    exp_w   = '0;
    exp_kc  = 0;
  endtask

  task automatic model_write(input logic [4:0] rd, input logic [31:0] d, input bit killed);
    if (!killed && rd != 5'd0) begin
      exp_rwe = 1'b1;
      exp_wr  = rd;
      exp_w   = d;
      exp_q.push_back(d);
    end else begin
      exp_rwe = 1'b0;
    end
  endtask

  task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                            input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bit   acc;
    ent_t e;
    acc = lv && (mq.size() < LD_DEPTH);
    if (av) begin
      foreach (mq[i]) begin
        if (mq[i].rd == ar && !mq[i].killed) begin
          mq[i].killed = 1'b1;
          exp_kc++;
        end
      end
      model_write(ar, ad, 1'b0);
      if (acc) begin
        e.rd = lr; e.d = ld; e.killed = (lr == ar);
        if (e.killed) exp_kc++;
        mq.push_back(e);
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      model_write(e.rd, e.d, e.killed);
      if (acc) begin
        e.rd = lr; e.d = ld; e.killed = 1'b0;
        mq.push_back(e);
      end
    end else if (acc) begin
      model_write(lr, ld, 1'b0);
    end else begin
      exp_rwe = 1'b0;
    end
  endtask

  // Driver: one clock of stimulus, ready checked before the edge, outputs after it.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    @(negedge t2);
    alu_v = av; alu_rd = ar; alu_d = ad;
    ld_v  = lv; ld_rd  = lr; ld_d  = ld;
    #1;
    last_rdy = ld_rdy;
    chk("ld_rdy", 32'(ld_rdy), 32'(mq.size() < LD_DEPTH));
    model_step(av, ar, ad, lv, lr, ld);
    @(posedge t2);
    #1;
    chk("rwe", 32'(rwe), 32'(exp_rwe));
    chk("wr", 32'(wr), 32'(exp_wr));
    chk("w", w, exp_w);
`ifdef WB_STATS_EN
    chk("kill_cnt", 32'(kill_cnt), 32'((exp_kc > 65535) ? 65535 : exp_kc));
`endif
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_v = 1'b0; alu_rd = '0; alu_d = '0;
    ld_v  = 1'b0; ld_rd  = '0; ld_d  = '0;
    model_reset();
    #23;
    chk("reset_rwe", 32'(rwe), 32'd0);
    chk("reset_wr", 32'(wr), 32'd0);
    chk("reset_w", w, 32'd0);
    chk("reset_rdy", 32'(ld_rdy), 32'd1);
    @(negedge t2);
    rst_n = 1'b1;
    idle();

    // Single ALU write appears one cycle later.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("alu_rwe", 32'(rwe), 32'd1);
    chk("alu_wr", 32'(wr), 32'd5);
    chk("alu_w", w, 32'h1234);
    idle();
    chk("idle_rwe", 32'(rwe), 32'd0);
    chk("idle_hold_w", w, 32'h1234);

    // ALU and load together: ALU first, load next cycle.
    step(1'b1, 5'd3, 32'h77, 1'b1, 5'd7, 32'hAA);
    chk("both_alu_wr", 32'(wr), 32'd3);
    idle();
    chk("both_ld_rwe", 32'(rwe), 32'd1);
    chk("both_ld_wr", 32'(wr), 32'd7);
    chk("both_ld_w", w, 32'hAA);

    // Three ALU writes back to back fill the buffer; loads drain in order afterwards.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hA1);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hA2);
    chk("full_rdy", 32'(last_rdy), 32'd0);
    idle();
    chk("drain0_wr", 32'(wr), 32'd10);
    chk("drain0_w", w, 32'hA0);
    idle();
    chk("drain1_wr", 32'(wr), 32'd11);
    chk("drain1_w", w, 32'hA1);
    idle();
    chk("drain_empty", 32'(rwe), 32'd0);

    // Buffered load to r9 superseded by an ALU write to r9.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    step(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    chk("kill_alu_wr", 32'(wr), 32'd9);
    chk("kill_alu_w", w, 32'h55);
    idle();
    chk("kill_slot_rwe", 32'(rwe), 32'd0);
    chk("kill_slot_w", w, 32'h55);
`ifdef WB_STATS_EN
    chk("kill_cnt_one", 32'(kill_cnt), 32'd1);
`endif

    // Writes to r0 never assert the enable.
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    chk("r0_rwe", 32'(rwe), 32'd0);

    // Reset mid-cycle with two loads buffered.
    step(1'b1, 5'd1, 32'h21, 1'b1, 5'd20, 32'hB0);
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd21, 32'hB1);
    @(negedge t2);
    alu_v = 1'b0; ld_v = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rwe", 32'(rwe), 32'd0);
    chk("midrst_rdy", 32'(ld_rdy), 32'd1);
    alu_v = 1'b1; alu_rd = 5'd4; alu_d = 32'hDEAD;
    ld_v  = 1'b1; ld_rd  = 5'd6; ld_d  = 32'hBEEF;
    @(posedge t2);
    #1;
    chk("inrst_rwe", 32'(rwe), 32'd0);
    chk("inrst_w", w, 32'd0);
    @(negedge t2);
    alu_v = 1'b0; ld_v = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1;
    chk("postrst_rdy", 32'(ld_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle();
    end
    chk("postrst_no_writes", 32'(exp_q.size()), 32'(0));

    // Random traffic with a small register range so kills and r0 writes are common.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 5'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0, 5'($urandom_range(0, 3)), $urandom);
    end
    for (int i = 0; i < LD_DEPTH + 2; i++) begin
      idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter LD_DEPTH, default 2, meaning load-buffer entries (legal 1..4).
REQ-002 SHALL have port t2  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_v  input  1  ALU result valid; always accepted, no backpressure.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_d  input  32  ALU result data.
REQ-007 SHALL have port ld_v  input  1  load result valid.
REQ-008 SHALL have port ld_rdy  output  1  load channel ready; combinational, = (count < LD_DEPTH).
REQ-009 SHALL have port ld_rd  input  5  load destination register.
REQ-010 SHALL have port ld_d  input  32  load data.
REQ-011 SHALL have port rwe  output  1  register-file write enable, registered.
REQ-012 SHALL have port wr  output  5  register-file write address, registered.
REQ-013 SHALL have port w  output  32  register-file write data, registered.

Function
REQ-014 SHALL accept a load on cycles where ld_v && ld_rdy.
REQ-015 SHALL select one write source per cycle, priority: ALU (alu_v) > load-buffer head (count>0) > accepted incoming load.
REQ-016 SHALL push an accepted load into the FIFO when not selected that cycle; push and pop allowed in the same cycle.
REQ-017 SHALL register the selection: source at edge N -> rwe/wr/w valid for cycle N+1; latency exactly 1 cycle.
REQ-018 SHALL drive rwe=0 when nothing is selected, when the selected rd is 0, or when the selected FIFO entry is killed; wr/w hold previous values when rwe=0.
REQ-019 SHALL, when alu_v, kill every FIFO entry, and any load accepted that same cycle, whose rd equals alu_rd (ALU write supersedes all pending loads to that register).
REQ-020 SHALL still pop killed entries in order, consuming a write slot with rwe=0.
REQ-021 SHALL keep FIFO order strictly; count SHALL never exceed LD_DEPTH nor underflow; pointers wrap modulo LD_DEPTH.
REQ-022 SHALL, with FIFO full and a simultaneous pop, hold ld_rdy=0 that cycle (ready does not look ahead).

Reset
REQ-023 SHALL on rst_n=0 asynchronously clear: rwe=0, wr=0, w=0, count=0, pointers=0, all kill flags=0.
REQ-024 SHALL discard buffered loads on reset mid-operation; ld_rdy=1 once rst_n=1 (LD_DEPTH>=1).
REQ-025 SHALL ignore alu_v/ld_v while rst_n=0.

Configuration
REQ-026 SHALL, with WB_STATS_EN defined, add output kill_cnt [15:0]: increments once per killed entry (multiple kills in one cycle add their total), saturates at 16'hFFFF, reset to 0.
REQ-027 SHALL, without WB_STATS_EN, omit kill_cnt and its counter logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: alu_v=1, rd=5, d=0x1234 at edge N -> rwe=1, wr=5, w=0x1234 in cycle N+1.
REQ-029 SHALL cover: alu_v and ld_v same cycle (ld rd=7, d=0xAA) -> ALU written N+1, load written N+2 with wr=7, w=0xAA.
REQ-030 SHALL cover: 3 consecutive ALU writes, loads offered each cycle, LD_DEPTH=2 -> ld_rdy=0 after 2 accepted; loads written in order once ALU stops.
REQ-031 SHALL cover: load rd=9 buffered, then alu_v rd=9 d=0x55 -> r9 written 0x55 only; later pop slot has rwe=0; kill_cnt=1 (WB_STATS_EN).
REQ-032 SHALL cover: alu_v rd=0 d=0xFFFF -> rwe=0 next cycle.
REQ-033 SHALL cover: FIFO holding 2 loads, rst_n pulsed low mid-cycle -> rwe=0 immediately, ld_rdy=1 after release, no buffered load ever written.
